// File: rtl/iram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : iram_loader                                                       |
// | Brief  : Host word stream -> broadcast program load into N core IRAMs.     |
// |          Optional read-back checksum verify via IRAM_LOADER_VERIFY_EN.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module iram_loader #(
    parameter int N  = 4,
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 abort,
    output logic [N-1:0]         write_en,
    output logic [N-1:0]         read_en,
    output logic [N-1:0][AW-1:0] addr,
    output logic [N-1:0][DW-1:0] Data_in,
    input  logic [N-1:0][DW-1:0] Data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [N-1:0]         err_core
);

    localparam int unsigned c_max_len = 2**AW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_LEN = 3'd1,
        S_LOAD    = 3'd2,
        S_VERIFY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

`ifdef IRAM_LOADER_VERIFY_EN
    localparam state_t c_after_load = S_VERIFY;
`else
    localparam state_t c_after_load = S_DONE;
`endif

    state_t        r_state;
    logic [N-1:0]  r_mask;
    logic [N-1:0]  r_write_en;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_sum;
    logic          r_error;
    logic          w_xfer;
    logic          w_len_ok;

`ifdef IRAM_LOADER_VERIFY_EN
    logic [N-1:0]          r_read_en;
    logic [N-1:0]          r_err_core;
    logic [N-1:0][DW-1:0]  r_vsum;
    logic                  r_issue_done;
    logic                  r_rd_active;
    logic                  r_rd_last;
    logic                  r_cap_vld;
    logic                  r_cap_last;
`endif

    assign s_ready  = (r_state == S_IDLE) || (r_state == S_HDR_LEN) || (r_state == S_LOAD);
    assign w_xfer   = s_valid && s_ready;
    assign w_len_ok = (s_data != '0) && (32'(s_data) <= c_max_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_write_en <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_sum      <= '0;
            r_error    <= 1'b0;
`ifdef IRAM_LOADER_VERIFY_EN
            r_read_en    <= '0;
            r_err_core   <= '0;
            r_vsum       <= '0;
            r_issue_done <= 1'b0;
            r_rd_active  <= 1'b0;
            r_rd_last    <= 1'b0;
            r_cap_vld    <= 1'b0;
            r_cap_last   <= 1'b0;
`endif
        end else begin
            r_write_en <= '0;
`ifdef IRAM_LOADER_VERIFY_EN
            r_read_en   <= '0;
            r_rd_active <= 1'b0;
            r_rd_last   <= 1'b0;
            r_cap_vld   <= r_rd_active;
            r_cap_last  <= r_rd_last;
`endif
            if (abort) begin
                r_state <= S_IDLE;
`ifdef IRAM_LOADER_VERIFY_EN
                r_cap_vld  <= 1'b0;
                r_cap_last <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_xfer) begin
                            if (s_data[N-1:0] == '0) begin
                                r_error <= 1'b1;
                            end else begin
                                r_mask  <= s_data[N-1:0];
                                r_error <= 1'b0;
`ifdef IRAM_LOADER_VERIFY_EN
                                r_err_core <= '0;
`endif
                                r_state <= S_HDR_LEN;
                            end
                        end
                    end
                    S_HDR_LEN: begin
                        if (w_xfer) begin
                            if (!w_len_ok) begin
                                r_error <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_last  <= AW'(s_data - DW'(1));
                                r_cnt   <= '0;
                                r_sum   <= '0;
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_xfer) begin
                            r_write_en <= r_mask;
                            r_addr     <= r_cnt;
                            r_wdata    <= s_data;
                            r_sum      <= r_sum + s_data;
                            if (r_cnt == r_last) begin
                                r_cnt   <= '0;
                                r_state <= c_after_load;
`ifdef IRAM_LOADER_VERIFY_EN
                                r_issue_done <= 1'b0;
                                r_vsum       <= '0;
`endif
                            end else begin
                                r_cnt <= r_cnt + AW'(1);
                            end
                        end
                    end
`ifdef IRAM_LOADER_VERIFY_EN
                    // Reads issue one per clock; captures trail by two clocks
                    // (read_en register, then IRAM read latency).
                    S_VERIFY: begin
                        if (!r_issue_done) begin
                            r_read_en   <= r_mask;
                            r_addr      <= r_cnt;
                            r_rd_active <= 1'b1;
                            r_rd_last   <= (r_cnt == r_last);
                            if (r_cnt == r_last) begin
                                r_issue_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + AW'(1);
                            end
                        end
                        if (r_cap_vld) begin
                            for (int i = 0; i < N; i++) begin
                                r_vsum[i] <= r_vsum[i] + Data_out[i];
                            end
                            if (r_cap_last) begin
                                for (int i = 0; i < N; i++) begin
                                    if (r_mask[i] && ((r_vsum[i] + Data_out[i]) != r_sum)) begin
                                        r_err_core[i] <= 1'b1;
                                        r_error       <= 1'b1;
                                    end
                                end
                                r_state <= S_DONE;
                            end
                        end
                    end
`endif
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_fanout
            assign addr[g]    = r_addr;
            assign Data_in[g] = r_wdata;
        end
    endgenerate

    assign write_en = r_write_en;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;

`ifdef IRAM_LOADER_VERIFY_EN
    assign read_en  = r_read_en;
    assign err_core = r_err_core;
`else
    logic w_unused_data_out;
    assign w_unused_data_out = ^Data_out;
    assign read_en  = '0;
    assign err_core = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_iram_loader                                                    |
// | Brief  : Directed self-checking bench for iram_loader with an IRAM model.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_iram_loader;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [15:0]       s_data;
    logic              abort;
    logic [3:0]        write_en;
    logic [3:0]        read_en;
    logic [3:0][8:0]   addr;
    logic [3:0][15:0]  Data_in;
    logic [3:0][15:0]  Data_out;
    logic              busy;
    logic              done;
    logic              error;
    logic [3:0]        err_core;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt, rd_cnt, done_cnt, exp_wa, wa_bad, last_wa;

    logic        r_corrupt = 1'b0;
    logic [15:0] mem [4][512];

    iram_loader #(.N(4), .AW(9), .DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .abort    (abort),
        .write_en (write_en),
        .read_en  (read_en),
        .addr     (addr),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_core (err_core)
    );

    always #5 clk = ~clk;

    // IRAM bank model; core 2 can flip bit 0 of its read at address 1.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write_en[i]) mem[i][addr[i]] <= Data_in[i];
            if (read_en[i])
                Data_out[i] <= mem[i][addr[i]] ^
                    ((r_corrupt && i == 2 && addr[i] == 9'd1) ? 16'h0001 : 16'h0000);
        end
    end

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_wa = 0; wa_bad = 0; last_wa = -1;
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (|write_en) begin
            wr_cnt++;
            last_wa = int'(addr[0]);
            if (int'(addr[0]) != exp_wa) wa_bad++;
            exp_wa++;
        end
        if (|read_en) rd_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic send(input logic [15:0] w);
        s_valid = 1'b1;
        s_data  = w;
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && busy; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_done_error got %b%b exp 00", done, error); end
        n_tests++; if (write_en !== 4'b0 || read_en !== 4'b0 || err_core !== 4'b0) begin
            n_fail++; $display("FAIL reset_enables got we=%b re=%b ec=%b exp 0", write_en, read_en, err_core); end
    endtask

    task automatic test_basic_load();
        logic [15:0] words [3] = '{16'h00A1, 16'h00B2, 16'h00C3};
        clear_counts();
        send(16'h0005);
        send(16'h0003);
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            n_tests++; if (write_en !== 4'b0101 || int'(addr[0]) != i || Data_in[0] !== words[i] || Data_in[2] !== words[i]) begin
                n_fail++; $display("FAIL basic_write%0d got we=%b addr=%0d d=%h exp we=0101 addr=%0d d=%h",
                                   i, write_en, addr[0], Data_in[0], i, words[i]); end
        end
        wait_idle(20);
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
        n_tests++; if (wr_cnt != 3 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_end got writes=%0d err=%b busy=%b exp 3 0 0", wr_cnt, error, busy); end
    endtask

    task automatic test_zero_mask();
        send(16'h0010);
        n_tests++; if (error !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_mask got err=%b busy=%b rdy=%b exp 1 0 1", error, busy, s_ready); end
        send(16'h000F);
        n_tests++; if (error !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL mask_accept got err=%b busy=%b rdy=%b exp 0 1 1", error, busy, s_ready); end
        abort = 1'b1; step(); abort = 1'b0;
        n_tests++; if (busy !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL abort_hdr got busy=%b err=%b exp 0 0", busy, error); end
    endtask

    task automatic test_bad_length();
        clear_counts();
        send(16'h0003); send(16'd0);
        n_tests++; if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL len_zero got err=%b busy=%b exp 1 0", error, busy); end
        send(16'h0003);
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL len_err_clear got %b exp 0", error); end
        send(16'd513);
        n_tests++; if (error !== 1'b1 || busy !== 1'b0 || wr_cnt != 0) begin
            n_fail++; $display("FAIL len_513 got err=%b busy=%b writes=%0d exp 1 0 0", error, busy, wr_cnt); end
    endtask

    task automatic test_full_depth();
        int sent = 0;
        clear_counts();
        send(16'h000F); send(16'd512);
        for (int cyc = 0; cyc < 5000 && sent < 512; cyc++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'(sent * 7 + 3);
            step();
            if (s_valid) sent++;
        end
        s_valid = 1'b0;
        wait_idle(600);
        n_tests++; if (wr_cnt != 512 || wa_bad != 0) begin
            n_fail++; $display("FAIL full_writes got writes=%0d addr_errs=%0d exp 512 0", wr_cnt, wa_bad); end
        n_tests++; if (last_wa != 511 || done_cnt != 1) begin
            n_fail++; $display("FAIL full_last got last_addr=%0d dones=%0d exp 511 1", last_wa, done_cnt); end
        n_tests++; if (mem[3][511] !== 16'(511 * 7 + 3) || mem[0][0] !== 16'd3 || error !== 1'b0) begin
            n_fail++; $display("FAIL full_data got m3[511]=%h m0[0]=%h err=%b exp %h 0003 0",
                               mem[3][511], mem[0][0], error, 16'(511 * 7 + 3)); end
    endtask

    task automatic test_abort();
        clear_counts();
        send(16'h0003); send(16'd5);
        send(16'h0011); send(16'h0022);
        n_tests++; if (write_en !== 4'b0011) begin n_fail++; $display("FAIL abort_pre_we got %b exp 0011", write_en); end
        abort = 1'b1; s_valid = 1'b1; s_data = 16'h0033;
        step();
        abort = 1'b0; s_valid = 1'b0;
        n_tests++; if (write_en !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_now got we=%b busy=%b done=%b exp 0 0 0", write_en, busy, done); end
        repeat (3) step();
        n_tests++; if (done_cnt != 0 || wr_cnt != 2 || error !== 1'b0 || mem[1][1] !== 16'h0022) begin
            n_fail++; $display("FAIL abort_after got dones=%0d writes=%0d err=%b m1[1]=%h exp 0 2 0 0022",
                               done_cnt, wr_cnt, error, mem[1][1]); end
    endtask

`ifdef IRAM_LOADER_VERIFY_EN
    task automatic test_verify();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            r_corrupt = (pass == 0);
            clear_counts();
            send(16'h0007); send(16'd4);
            send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
            lat = 0;
            while (!done && lat < 20) begin step(); lat++; end
            n_tests++; if (lat != 6 || rd_cnt != 4) begin
                n_fail++; $display("FAIL verify%0d_latency got lat=%0d reads=%0d exp 6 4", pass, lat, rd_cnt); end
            n_tests++; if (err_core !== (pass == 0 ? 4'b0100 : 4'b0000) || error !== (pass == 0)) begin
                n_fail++; $display("FAIL verify%0d_result got ec=%b err=%b exp %b %b",
                                   pass, err_core, error, (pass == 0 ? 4'b0100 : 4'b0000), (pass == 0)); end
            wait_idle(10);
        end
        r_corrupt = 1'b0;
    endtask
`else
    task automatic test_verify();
        clear_counts();
        send(16'h0007); send(16'd4);
        send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
        n_tests++; if (done !== 1'b1 || write_en !== 4'b0111 || int'(addr[0]) != 3) begin
            n_fail++; $display("FAIL noverify_done got done=%b we=%b addr=%0d exp 1 0111 3", done, write_en, addr[0]); end
        wait_idle(10);
        n_tests++; if (rd_cnt != 0 || err_core !== 4'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL noverify_reads got reads=%0d ec=%b busy=%b exp 0 0 0", rd_cnt, err_core, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_zero_mask();
        test_bad_length();
        test_full_depth();
        test_abort();
        test_verify();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
